// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with registered pop data, same-cycle replace-top,
// synchronous flush and sticky overflow/underflow flags.
`default_nettype none

module param_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_word;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));
  assign top_idx  = AW'(sp_q - 1'b1);
  assign top_word = mem_q[top_idx];

  always_comb begin
    sp_d      = sp_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = top_idx;

    // Clear first so an error raised in the same cycle overrides it.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (flush) begin
      sp_d = '0;
    end else if (push && pop) begin
      valid_d = 1'b1;
      if (is_empty) begin
        dout_d = data_in;
      end else begin
        dout_d = top_word;
        mem_we = 1'b1;
      end
    end else if (push) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = AW'(sp_q);
        sp_d      = sp_q + 1'b1;
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        dout_d  = top_word;
        sp_d    = sp_q - 1'b1;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately unreset; entries above sp are never observable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= data_in;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = valid_q;
  assign top       = is_empty ? '0 : top_word;
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

`default_nettype wire
